// File: rtl/apb_multi_slave_bridge.sv
// apb_multi_slave_bridge: APB decoder/mux fanning one master out to NUM_SLV slaves
// with native or generated ready, per-transfer timeout and a saturating error counter
module apb_multi_slave_bridge #(
  parameter int         NUM_SLV    = 2,
  parameter int         ADDR_W     = 19,
  parameter int         DATA_W     = 32,
  parameter int         SEL_LSB    = 17,
  parameter int         SEL_W      = 1,
  parameter logic [7:0] NATIVE_RDY = 8'h01,
  parameter int         RD_WAIT    = 2,
  parameter int         WR_WAIT    = 0,
  parameter int         TIMEOUT    = 255
) (
  input  logic                      apb_clk,
  input  logic                      apb_rst_n,
  input  logic [ADDR_W-1:0]         apb_paddr,
  input  logic                      apb_psel,
  input  logic                      apb_penable,
  input  logic                      apb_pwrite,
  input  logic [DATA_W-1:0]         apb_pwdata,
  output logic                      apb_pready,
  output logic [DATA_W-1:0]         apb_prdata,
  output logic                      apb_pslverr,
  output logic [ADDR_W-1:0]         slv_paddr,
  output logic                      slv_pwrite,
  output logic                      slv_penable,
  output logic [DATA_W-1:0]         slv_pwdata,
  output logic [NUM_SLV-1:0]        slv_psel,
  input  logic [NUM_SLV*DATA_W-1:0] slv_prdata,
  input  logic [NUM_SLV-1:0]        slv_pready,
  input  logic [NUM_SLV-1:0]        slv_pslverr,
  output logic [7:0]                err_cnt
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, ERR = 2'd2;
  logic [1:0] state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d, idx_in, idx_cur;
  logic wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] err_q, err_d;
  logic in_idle, in_acc, in_err, setup, xfer, native, rdy_n, err_n, rdy_raw, to_hit, err_evt, sel_en, sel_any;
  logic [DATA_W-1:0] rd_n;

  assign idx_in  = apb_paddr[SEL_LSB +: SEL_W];
  assign in_idle = state_q == IDLE;
  assign in_acc  = state_q == ACCESS;
  assign in_err  = state_q == ERR;
  assign setup   = apb_psel & ~apb_penable;
  assign xfer    = apb_psel & apb_penable;
  assign idx_cur = in_idle ? idx_in : idx_q;

  always_comb begin
    native = 1'b0;
    rdy_n  = 1'b0;
    err_n  = 1'b0;
    rd_n   = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (idx_q == SEL_W'(i)) begin
        native = NATIVE_RDY[i];
        rdy_n  = slv_pready[i];
        err_n  = slv_pslverr[i];
        rd_n   = slv_prdata[i*DATA_W +: DATA_W];
      end
  end

  // one counter serves as both wait and timeout count: both start at 0 and advance together
  assign rdy_raw     = native ? rdy_n : cnt_q == CW'(wr_q ? WR_WAIT : RD_WAIT);
  assign to_hit      = in_acc & xfer & ~rdy_raw & (cnt_q == CW'(TIMEOUT));
  assign apb_pready  = (in_acc & xfer & (rdy_raw | to_hit)) | (in_err & xfer);
  assign apb_pslverr = (in_acc & xfer & (to_hit | (native & rdy_n & err_n))) | (in_err & xfer);
  assign apb_prdata  = (in_acc & xfer & rdy_raw & ~wr_q) ? rd_n : '0;
  assign err_evt     = to_hit | (in_err & xfer);

  // reset gates selects so they drop asynchronously even if the master holds psel
  assign sel_en = apb_rst_n & apb_psel & (in_idle ? ~apb_penable : in_acc & ~to_hit);

  always_comb begin
    slv_psel = '0;
    for (int i = 0; i < NUM_SLV; i++)
      slv_psel[i] = sel_en & (idx_cur == SEL_W'(i));
  end

  assign sel_any     = |slv_psel;
  assign slv_paddr   = sel_any ? apb_paddr : '0;
  assign slv_pwdata  = sel_any ? apb_pwdata : '0;
  assign slv_pwrite  = sel_any & apb_pwrite;
  assign slv_penable = sel_any & apb_penable;
  assign err_cnt     = err_q;

  always_comb begin
    state_d = in_idle ? (setup ? (int'(idx_in) < NUM_SLV ? ACCESS : ERR) : IDLE)
                      : ((~apb_psel | apb_pready) ? IDLE : state_q);
    idx_d   = (in_idle & setup) ? idx_in : idx_q;
    wr_d    = (in_idle & setup) ? apb_pwrite : wr_q;
    cnt_d   = (in_acc & xfer & ~apb_pready) ? cnt_q + CW'(1) : '0;
    err_d   = (err_evt & ~&err_q) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n)
    if (!apb_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// tb_apb_multi_slave_bridge: directed checks of a default 2-slave bridge (d0)
// and a 3-slave, 2-bit select, TIMEOUT=16 bridge (d1)
module tb_apb_multi_slave_bridge;
  logic clk = 1'b0;
  logic rst_n, dut, psel, penable, pwrite, spready, spslverr;
  logic [18:0] paddr;
  logic [31:0] pwdata;
  logic [63:0] srd0 = {32'hBBBB_1111, 32'hAAAA_0000};
  logic [95:0] srd1 = {32'hCCCC_2222, 32'h9999_1111, 32'h8888_0000};
  logic p0_rdy, p0_err, s0_wr, s0_en, p1_rdy, p1_err, s1_wr, s1_en;
  logic [31:0] p0_rd, s0_wd, p1_rd, s1_wd;
  logic [18:0] s0_addr, s1_addr;
  logic [1:0] s0_sel;
  logic [2:0] s1_sel;
  logic [7:0] e0, e1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  apb_multi_slave_bridge d0 (
    .apb_clk(clk), .apb_rst_n(rst_n), .apb_paddr(paddr), .apb_psel(psel & ~dut),
    .apb_penable(penable), .apb_pwrite(pwrite), .apb_pwdata(pwdata),
    .apb_pready(p0_rdy), .apb_prdata(p0_rd), .apb_pslverr(p0_err),
    .slv_paddr(s0_addr), .slv_pwrite(s0_wr), .slv_penable(s0_en), .slv_pwdata(s0_wd),
    .slv_psel(s0_sel), .slv_prdata(srd0), .slv_pready({2{spready}}),
    .slv_pslverr({2{spslverr}}), .err_cnt(e0));

  apb_multi_slave_bridge #(.NUM_SLV(3), .SEL_W(2), .TIMEOUT(16)) d1 (
    .apb_clk(clk), .apb_rst_n(rst_n), .apb_paddr(paddr), .apb_psel(psel & dut),
    .apb_penable(penable), .apb_pwrite(pwrite), .apb_pwdata(pwdata),
    .apb_pready(p1_rdy), .apb_prdata(p1_rd), .apb_pslverr(p1_err),
    .slv_paddr(s1_addr), .slv_pwrite(s1_wr), .slv_penable(s1_en), .slv_pwdata(s1_wd),
    .slv_psel(s1_sel), .slv_prdata(srd1), .slv_pready({3{spready}}),
    .slv_pslverr({3{spslverr}}), .err_cnt(e1));

  logic m_rdy, m_err;
  logic [31:0] m_rd, c_wd;
  logic [18:0] c_addr;
  logic [7:0] c_sel, setup_sel, acc_sel;
  logic [31:0] acc_wd, rd;
  logic [18:0] acc_addr;
  logic er;
  int n;

  assign m_rdy  = dut ? p1_rdy : p0_rdy;
  assign m_err  = dut ? p1_err : p0_err;
  assign m_rd   = dut ? p1_rd : p0_rd;
  assign c_sel  = dut ? {5'b0, s1_sel} : {6'b0, s0_sel};
  assign c_wd   = dut ? s1_wd : s0_wd;
  assign c_addr = dut ? s1_addr : s0_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // full transfer; slave pready pulses only in access cycle rdy_at, the cycle budget bounds the wait
  task automatic xfer(input logic [18:0] a, input logic w, input logic [31:0] wd, input int rdy_at,
                      output logic [31:0] r, output logic e, output int cyc);
    @(posedge clk); #1;
    paddr = a; pwrite = w; pwdata = wd; psel = 1'b1; penable = 1'b0; spready = 1'b0;
    #2 setup_sel = c_sel;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1;
    forever begin
      spready = (cyc == rdy_at);
      #2;
      if (m_rdy || cyc >= 400) break;
      @(posedge clk); #1;
      cyc++;
    end
    r = m_rd; e = m_err; acc_sel = c_sel; acc_wd = c_wd; acc_addr = c_addr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; spready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dut = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 19'h20004; pwdata = '0; spready = 1'b0; spslverr = 1'b0;
    #3;
    chk("rst_sel", c_sel, 0);
    chk("rst_rdy", p0_rdy, 0);
    chk("rst_cnt", e0, 0);
    @(posedge clk); #1 psel = 1'b0; rst_n = 1'b1;
    // d0: generated read with two wait states on slave 1
    xfer(19'h20004, 1'b0, 32'h0, 1000, rd, er, n);
    chk("rd_setup_sel", setup_sel, 8'b10);
    chk("rd_cycles", n, 3);
    chk("rd_data", rd, 32'hBBBB_1111);
    chk("rd_err", er, 0);
    // zero-wait write
    xfer(19'h20010, 1'b1, 32'hDEAD_BEEF, 1000, rd, er, n);
    chk("wr_cycles", n, 1);
    chk("wr_sel", acc_sel, 8'b10);
    chk("wr_wdata", acc_wd, 32'hDEAD_BEEF);
    chk("wr_addr", acc_addr, 19'h20010);
    chk("wr_rdata", rd, 0);
    // native slave 0, ready after 4 low cycles with slave error
    spslverr = 1'b1;
    xfer(19'h00100, 1'b0, 32'h0, 5, rd, er, n);
    chk("nat_cycles", n, 5);
    chk("nat_err", er, 1);
    chk("nat_data", rd, 32'hAAAA_0000);
    chk("nat_sel", setup_sel, 8'b01);
    spslverr = 1'b0;
    chk("nat_cnt", e0, 0);
    // abort: master drops psel mid-access
    @(posedge clk); #1 paddr = 19'h00100; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort_pre_sel", c_sel, 8'b01);
    psel = 1'b0; penable = 1'b0;
    #1 chk("abort_sel", c_sel, 0);
    @(posedge clk); #1 chk("abort_cnt", e0, 0);
    xfer(19'h20004, 1'b0, 32'h0, 1000, rd, er, n);
    chk("post_abort_cycles", n, 3);
    // d1: highest valid slave, then decode error on idx 3
    dut = 1'b1;
    xfer(19'h40000, 1'b0, 32'h0, 1000, rd, er, n);
    chk("s2_sel", setup_sel, 8'b100);
    chk("s2_data", rd, 32'hCCCC_2222);
    xfer(19'h60000, 1'b0, 32'h0, 1000, rd, er, n);
    chk("dec_sel", setup_sel, 0);
    chk("dec_cycles", n, 1);
    chk("dec_err", er, 1);
    chk("dec_data", rd, 0);
    chk("dec_cnt", e1, 1);
    // timeout on never-ready native slave 0
    xfer(19'h00040, 1'b0, 32'h0, 1000, rd, er, n);
    chk("to_cycles", n, 17);
    chk("to_err", er, 1);
    chk("to_data", rd, 0);
    chk("to_sel", acc_sel, 0);
    chk("to_cnt", e1, 2);
    for (int k = 0; k < 298; k++) xfer(19'h00040, 1'b0, 32'h0, 1000, rd, er, n);
    chk("sat_cnt", e1, 8'hFF);
    // reset during an access
    @(posedge clk); #1 paddr = 19'h00040; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", c_sel, 0);
    chk("rst_mid_cnt", e1, 0);
    chk("rst_mid_rdy", m_rdy, 0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    xfer(19'h20000, 1'b0, 32'h0, 1000, rd, er, n);
    chk("post_rst_cycles", n, 3);
    chk("post_rst_data", rd, 32'h9999_1111);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
